// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: synchronised bit sampling, frame lock FSM, valid/ready output with sticky errors
// Standard I2S (one-bit delay) framing; every output is registered.
module i2s_rx #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            aud_bclk_i,
  input  logic            aud_lrclk_i,
  input  logic            aud_sda_i,
  output logic [2*DW-1:0] sample_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            locked_o,
  output logic            overrun_o,
  output logic            frame_err_o,
  input  logic            clr_err_i
);

  localparam int CW = $clog2(DW + 2);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   bclk_d;
  logic                   lr_prev;
  logic [DW-1:0]          shreg;
  logic [DW-1:0]          left_word;
  logic [CW-1:0]          cnt;

  logic          bit_evt;
  logic          lr_s;
  logic          sda_s;
  logic          boundary;
  logic          word_ok;
  logic          frame_done;
  logic          err_evt;
  logic          drop;
  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] shreg_nxt;

  assign bit_evt    = bclk_sync[SYNC_STAGES-1] & ~bclk_d;
  assign lr_s       = lr_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign shreg_nxt  = {shreg[DW-2:0], sda_s};
  assign cnt_inc    = (cnt == CW'(DW + 1)) ? cnt : cnt + 1'b1;
  // Bit count includes the boundary bit, which is the LSB of the word just ending.
  assign boundary   = bit_evt & (lr_s != lr_prev);
  assign word_ok    = (cnt_inc == CW'(DW));
  assign frame_done = boundary & (state == RIGHT) & ~lr_s & word_ok;
  assign err_evt    = boundary & (state != HUNT) & ~word_ok;
  assign drop       = valid_o & ~ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sda_sync  <= '0;
      bclk_d    <= 1'b0;
      lr_prev   <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk_i};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], aud_lrclk_i};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], aud_sda_i};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      if (bit_evt) begin
        lr_prev <= lr_s;
        shreg   <= shreg_nxt;
        cnt     <= boundary ? '0 : cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= HUNT;
      locked_o  <= 1'b0;
      left_word <= '0;
    end else if (boundary) begin
      case (state)
        HUNT: begin
          if (!lr_s) begin
            state    <= LEFT;
            locked_o <= 1'b1;
          end
        end
        LEFT: begin
          if (word_ok) begin
            left_word <= shreg_nxt;
            state     <= RIGHT;
          end else begin
            state    <= HUNT;
            locked_o <= 1'b0;
          end
        end
        // A short/long right word still ends on a 1->0 edge, so resync lands straight back in LEFT.
        RIGHT: begin
          state    <= LEFT;
          locked_o <= 1'b1;
        end
        default: begin
          state    <= HUNT;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o    <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (frame_done && !drop) begin
        sample_o <= {left_word, shreg_nxt};
        valid_o  <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (frame_done && drop)
        overrun_o <= 1'b1;
      else if (clr_err_i)
        overrun_o <= 1'b0;
      if (err_evt)
        frame_err_o <= 1'b1;
      else if (clr_err_i)
        frame_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed/randomised bench for i2s_rx with a behavioural I2S transmitter
`timescale 1ns/1ps
module tb_i2s_rx;

  logic        clk;
  logic        rst;
  logic        bclk;
  logic        lrclk;
  logic        sda;
  logic [31:0] sample;
  logic        valid;
  logic        ready;
  logic        locked;
  logic        overrun;
  logic        frame_err;
  logic        clr_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit          q_ch[$];
  bit          q_bit[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          fast = 0;
  real         half_ns = 325.5;

  i2s_rx #(.DW(16), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .aud_bclk_i  (bclk),
    .aud_lrclk_i (lrclk),
    .aud_sda_i   (sda),
    .sample_o    (sample),
    .valid_o     (valid),
    .ready_i     (ready),
    .locked_o    (locked),
    .overrun_o   (overrun),
    .frame_err_o (frame_err),
    .clr_err_i   (clr_err)
  );

  initial clk = 0;
  always #18.5185 clk = ~clk;

  // Consumer side: every cycle with valid && ready is one accepted frame.
  always @(negedge clk)
    if (!rst && valid && ready) got_q.push_back(sample);

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one word MSB first on channel ch (0 = left, 1 = right).
  task automatic push_word(input logic [31:0] w, input int nbits, input bit ch);
    for (int i = nbits - 1; i >= 0; i--) begin
      q_ch.push_back(ch);
      q_bit.push_back(w[i]);
    end
  endtask

  task automatic push_frame(input logic [31:0] f);
    push_word({16'h0, f[31:16]}, 16, 1'b0);
    push_word({16'h0, f[15:0]}, 16, 1'b1);
  endtask

  // I2S one-bit delay: word select during a slot already names the channel of the following slot.
  task automatic flush(input bit next_ch);
    bit b;
    while (q_ch.size() > 0) begin
      void'(q_ch.pop_front());
      b = q_bit.pop_front();
      bclk  = 0;
      lrclk = (q_ch.size() > 0) ? q_ch[0] : next_ch;
      sda   = b;
      if (fast) half_ns = $urandom_range(4, 7) * 37.037 + 1.3;
      #(half_ns);
      bclk = 1;
      if (fast) half_ns = $urandom_range(4, 7) * 37.037 + 2.1;
      #(half_ns);
    end
    wait_clks(8);
  endtask

  task automatic accept_one();
    @(posedge clk);
    #1 ready = 1;
    @(posedge clk);
    #1 ready = 0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1;
    @(posedge clk);
    #1 clr_err = 0;
  endtask

  initial begin
    logic [31:0] f1, f2, f3, f4, f5, f6, f7, w;
    rst = 1; bclk = 0; lrclk = 0; sda = 0; ready = 0; clr_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", sample, 32'h0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 0;
    wait_clks(2);

    // Acquisition from the middle of a right word, then the nominal frame.
    push_word($urandom, 9, 1'b1);
    push_word(32'h0000_A5C3, 16, 1'b0);
    flush(1'b1);
    check("acq_no_valid", valid, 0);
    check("acq_locked", locked, 1);
    push_word(32'h0000_0F01, 16, 1'b1);
    flush(1'b0);
    check("nom1_valid", valid, 1);
    check("nom1_sample", sample, 32'hA5C3_0F01);
    check("nom1_locked", locked, 1);
    accept_one();
    exp_q.push_back(32'hA5C3_0F01);
    check("nom1_valid_clr", valid, 0);
    push_frame(32'hA5C3_0F01);
    flush(1'b0);
    check("nom2_valid", valid, 1);
    check("nom2_sample", sample, 32'hA5C3_0F01);
    check("nom2_locked", locked, 1);
    check("nom2_overrun", overrun, 0);
    accept_one();
    exp_q.push_back(32'hA5C3_0F01);

    fast = 1;
    // Backpressure: the second frame is dropped.
    f1 = $urandom; f2 = $urandom;
    push_frame(f1);
    push_frame(f2);
    flush(1'b0);
    check("bp_valid", valid, 1);
    check("bp_sample", sample, f1);
    check("bp_overrun", overrun, 1);
    pulse_clr();
    check("bp_overrun_clr", overrun, 0);
    accept_one();
    exp_q.push_back(f1);

    // Framing error: a 15-bit left word.
    ready = 1;
    f3 = $urandom;
    push_word(f3, 15, 1'b0);
    flush(1'b1);
    check("ferr_flag", frame_err, 1);
    check("ferr_unlocked", locked, 0);
    push_word($urandom, 16, 1'b1);
    flush(1'b0);
    check("ferr_relock", locked, 1);
    f4 = $urandom;
    push_frame(f4);
    flush(1'b0);
    exp_q.push_back(f4);
    check("ferr_locked_after", locked, 1);
    pulse_clr();
    check("ferr_clr", frame_err, 0);

    // Reset during bit 7 of a right word.
    ready = 0;
    wait_clks(2);
    f5 = $urandom; f6 = $urandom;
    push_frame(f5);
    push_frame(f6);
    flush(1'b0);
    check("prerst_valid", valid, 1);
    check("prerst_overrun", overrun, 1);
    w = $urandom;
    push_word($urandom, 16, 1'b0);
    push_word({16'h0, w[15:0]} >> 9, 7, 1'b1);
    flush(1'b1);
    rst = 1;
    #1;
    check("midrst_sample", sample, 32'h0);
    check("midrst_valid", valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frame_err", frame_err, 0);
    wait_clks(3);
    rst = 0;
    ready = 1;
    push_word(w, 9, 1'b1);
    f7 = $urandom;
    push_frame(f7);
    flush(1'b0);
    exp_q.push_back(f7);

    // Loopback ramp with jittered bit clock.
    for (int i = 0; i < 100; i++) begin
      push_frame(32'h0001_0002 + i);
      exp_q.push_back(32'h0001_0002 + i);
    end
    flush(1'b0);
    check("lb_overrun", overrun, 0);
    check("lb_frame_err", frame_err, 0);
    check("lb_locked", locked, 1);

    check("rx_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rx_frame_%0d", i), got_q[i], exp_q[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
